// File: rtl/adder_result_checker_if.sv
// Vector/response bundle between an adder stimulus source and adder_result_checker.
// master = stimulus/DUT side, slave = checker side.
`timescale 1ns/1ps
interface adder_result_checker_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic               start;
    logic               stop;
    logic               vec_valid;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               ci;
    logic [WIDTH-1:0]   dut_s;
    logic               dut_co;
    logic               dut_of;
    logic               busy;
    logic               done;
    logic               cmp_valid;
    logic               match;
    logic [CNT_W-1:0]   pass_cnt;
    logic [CNT_W-1:0]   fail_cnt;
    logic               fail_seen;
    logic [WIDTH-1:0]   fail_a;
    logic [WIDTH-1:0]   fail_b;
    logic               fail_ci;
    logic [WIDTH+1:0]   fail_exp;

    modport master (
        output start, stop, vec_valid, a, b, ci, dut_s, dut_co, dut_of,
        input  busy, done, cmp_valid, match, pass_cnt, fail_cnt,
               fail_seen, fail_a, fail_b, fail_ci, fail_exp
    );

    modport slave (
        input  start, stop, vec_valid, a, b, ci, dut_s, dut_co, dut_of,
        output busy, done, cmp_valid, match, pass_cnt, fail_cnt,
               fail_seen, fail_a, fail_b, fail_ci, fail_exp
    );
endinterface

// File: rtl/adder_result_checker.sv
// Response checker for an adder under test: golden {of, co, s} delayed LAT cycles,
// compared against the DUT outputs, with saturating pass/fail counts and first-fail capture.
`timescale 1ns/1ps
module adder_result_checker #(
    parameter int WIDTH = 8,
    parameter int LAT   = 2,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    adder_result_checker_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ci;
        logic [WIDTH+1:0] exp;   // {of, co, s}
    } vec_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_cmp_valid;
    logic             r_match;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic             r_fail_seen;
    logic [WIDTH-1:0] r_fail_a;
    logic [WIDTH-1:0] r_fail_b;
    logic             r_fail_ci;
    logic [WIDTH+1:0] r_fail_exp;

    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic             w_of;
    vec_t             w_in;
    vec_t             w_tap;
    logic             w_tap_valid;
    logic             w_pipe_busy;
    logic             w_match;

    // NOTE: every signal driven from always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        w_accept = (r_state == ST_RUN) && bus.vec_valid && !bus.stop;
        w_sum    = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.ci};
        w_of     = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
        w_in.a   = bus.a;
        w_in.b   = bus.b;
        w_in.ci  = bus.ci;
        w_in.exp = {w_of, w_sum};
    end

    if (LAT == 0) begin : g_comb
        // Combinational DUT: its outputs belong to the vector being accepted right now.
        always_comb begin
            w_tap       = w_in;
            w_tap_valid = w_accept;
            w_pipe_busy = 1'b0;
        end
    end else begin : g_pipe
        logic [LAT-1:0] r_valid;
        vec_t           r_data [LAT];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= '0;
            end else begin
                r_valid[0] <= w_accept;
                for (int i = 1; i < LAT; i++) begin
                    r_valid[i] <= r_valid[i-1];
                end
            end
        end

        // NOTE: only the valid bits are reset; the data stages are don't-care while invalid,
        // so they stay a plain reset-free shift register.
        always_ff @(posedge clk) begin
            r_data[0] <= w_in;
            for (int i = 1; i < LAT; i++) begin
                r_data[i] <= r_data[i-1];
            end
        end

        always_comb begin
            w_tap       = r_data[LAT-1];
            w_tap_valid = r_valid[LAT-1];
            w_pipe_busy = |r_valid;
        end
    end

    assign w_match = ({bus.dut_of, bus.dut_co, bus.dut_s} == w_tap.exp);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cmp_valid <= 1'b0;
            r_match     <= 1'b0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_fail_seen <= 1'b0;
            r_fail_a    <= '0;
            r_fail_b    <= '0;
            r_fail_ci   <= 1'b0;
            r_fail_exp  <= '0;
        end else begin
            r_cmp_valid <= w_tap_valid;
            r_match     <= w_tap_valid && w_match;

            if (w_tap_valid) begin
                if (w_match) begin
                    if (r_pass_cnt != CNT_MAX) r_pass_cnt <= r_pass_cnt + CNT_ONE;
                end else begin
                    if (r_fail_cnt != CNT_MAX) r_fail_cnt <= r_fail_cnt + CNT_ONE;
                    if (!r_fail_seen) begin
                        r_fail_a   <= w_tap.a;
                        r_fail_b   <= w_tap.b;
                        r_fail_ci  <= w_tap.ci;
                        r_fail_exp <= w_tap.exp;
                    end
                    r_fail_seen <= 1'b1;
                end
            end

            // Placed after the update above so a start clear always wins on its edge.
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_state     <= ST_RUN;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass_cnt  <= '0;
                        r_fail_cnt  <= '0;
                        r_fail_seen <= 1'b0;
                        r_fail_a    <= '0;
                        r_fail_b    <= '0;
                        r_fail_ci   <= 1'b0;
                        r_fail_exp  <= '0;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!w_pipe_busy) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.cmp_valid = r_cmp_valid;
    assign bus.match     = r_match;
    assign bus.pass_cnt  = r_pass_cnt;
    assign bus.fail_cnt  = r_fail_cnt;
    assign bus.fail_seen = r_fail_seen;
    assign bus.fail_a    = r_fail_a;
    assign bus.fail_b    = r_fail_b;
    assign bus.fail_ci   = r_fail_ci;
    assign bus.fail_exp  = r_fail_exp;
endmodule
